// File: rtl/alu_issue_seq.sv
// Issue sequencer for the 8-bit ALU: accepts one instruction, reads a 4x8 register file, drives the ALU for one cycle, writes back and presents the result.
// Optional build macro: ALU_ISSUE_SEQ_RESERVED_TRAP_EN traps reserved opcodes 100/101/110 instead of issuing them.
module alu_issue_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_ld,
    input  logic [2:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs1,
    input  logic [1:0] in_rs2,
    input  logic [7:0] in_imm,
    output logic [2:0] alu_funsel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_zero,
    output logic       out_err
);

    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

    state_t      state_reg, state_next;
    logic        ld_reg;
    logic [2:0]  op_reg;
    logic [1:0]  rd_reg, rs1_reg, rs2_reg;
    logic [7:0]  imm_reg;
    logic [7:0]  rf_reg [4];
    logic [7:0]  out_data_reg;
    logic        out_zero_reg;
    logic        out_err_reg;

    logic        trap;
    logic        issue;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_zero;

`ifdef ALU_ISSUE_SEQ_RESERVED_TRAP_EN
    assign trap = !ld_reg && op_reg[2] && (op_reg != 3'b111);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = EXEC;
            end
            EXEC: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The ALU only sees an operation in EXEC; loads and trapped opcodes leave it idle.
    assign issue      = (state_reg == EXEC) && !ld_reg && !trap;
    assign alu_funsel = issue ? op_reg : 3'b000;
    assign alu_a      = issue ? rf_reg[rs1_reg] : 8'h00;
    assign alu_b      = issue ? rf_reg[rs2_reg] : 8'h00;

    assign wr_en   = (state_reg == EXEC) && !trap;
    assign wr_data = ld_reg ? imm_reg : alu_result;
    assign wr_zero = ld_reg ? (imm_reg == 8'h00) : alu_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_reg  <= 1'b0;
            op_reg  <= 3'b000;
            rd_reg  <= 2'd0;
            rs1_reg <= 2'd0;
            rs2_reg <= 2'd0;
            imm_reg <= 8'h00;
        end else if (in_valid && in_ready) begin
            ld_reg  <= in_ld;
            op_reg  <= in_op;
            rd_reg  <= in_rd;
            rs1_reg <= in_rs1;
            rs2_reg <= in_rs2;
            imm_reg <= in_imm;
        end
    end

    // Operands are read combinationally during EXEC, so rd==rs sees the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf_reg[i] <= 8'h00;
        end else if (wr_en) begin
            rf_reg[rd_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg <= 8'h00;
            out_zero_reg <= 1'b0;
            out_err_reg  <= 1'b0;
        end else if (state_reg == EXEC) begin
            out_data_reg <= trap ? 8'h00 : wr_data;
            out_zero_reg <= trap ? 1'b0 : wr_zero;
            out_err_reg  <= trap;
        end
    end

    assign out_data = out_data_reg;
    assign out_zero = out_zero_reg;
    assign out_err  = out_err_reg;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed scenarios plus randomized instructions against a register-file reference model.
module tb_alu_issue_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_ld;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic [7:0] in_imm;
    logic [2:0] alu_funsel;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;
    logic       out_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] mrf [4];

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ld(in_ld), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_funsel(alu_funsel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_err(out_err)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b111:  return (a < b) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // Environment model of the combinational ALU downstream of the sequencer.
    assign alu_result = alu_f(alu_funsel, alu_a, alu_b);
    assign alu_zero   = (alu_result == 8'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_trap(input logic ld, input logic [2:0] op);
`ifdef ALU_ISSUE_SEQ_RESERVED_TRAP_EN
        return !ld && (op == 3'b100 || op == 3'b101 || op == 3'b110);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one instruction from a negedge; returns on the negedge where in_ready is back.
    task automatic issue(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                         input int stall);
        logic       trap;
        logic [7:0] res, ea, eb, edata;
        logic [2:0] ef;
        int         n;
        trap  = is_trap(ld, op);
        res   = ld ? imm : alu_f(op, mrf[rs1], mrf[rs2]);
        ef    = (!ld && !trap) ? op : 3'b000;
        ea    = (!ld && !trap) ? mrf[rs1] : 8'h00;
        eb    = (!ld && !trap) ? mrf[rs2] : 8'h00;
        edata = trap ? 8'h00 : res;

        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);

        in_valid = 1'b1; in_ld = ld; in_op = op; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = (stall == 0);
        check("exec_funsel", 32'(alu_funsel), 32'(ef));
        check("exec_a", 32'(alu_a), 32'(ea));
        check("exec_b", 32'(alu_b), 32'(eb));
        check("exec_in_ready", 32'(in_ready), 32'd0);
        check("exec_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data", 32'(out_data), 32'(edata));
        check("out_zero", 32'(out_zero), 32'(!trap && res == 8'd0));
        check("out_err", 32'(out_err), 32'(trap));
        for (int i = 0; i < stall; i++) begin
            // Spurious offers while stalled must be refused.
            in_valid = 1'b1; in_ld = 1'b1; in_rd = 2'($urandom); in_imm = 8'($urandom);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'(edata));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("done_out_valid", 32'(out_valid), 32'd0);
        if (!trap) mrf[rd] = res;
    endtask

    task automatic readback(input logic [1:0] r);
        issue(1'b0, 3'b001, r, r, r, 8'h00, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
        rst = 1'b1; in_valid = 1'b0; in_ld = 1'b0; in_op = 3'b000;
        in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0; in_imm = 8'h00; out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_alu_ports", {21'd0, alu_funsel, alu_a}, 32'd0);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ignores_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        issue(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h05, 0);
        issue(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h03, 0);
        issue(1'b0, 3'b010, 2'd0, 2'd1, 2'd2, 8'h00, 0);
        check("add_r0_model", 32'(mrf[0]), 32'h08);
        readback(2'd0);
        issue(1'b0, 3'b011, 2'd3, 2'd2, 2'd1, 8'h00, 0);
        check("sub_wrap_model", 32'(mrf[3]), 32'hFE);
        issue(1'b0, 3'b011, 2'd3, 2'd1, 2'd1, 8'h00, 0);
        issue(1'b0, 3'b111, 2'd0, 2'd2, 2'd1, 8'h00, 0);
        issue(1'b0, 3'b111, 2'd0, 2'd1, 2'd2, 8'h00, 0);
        issue(1'b0, 3'b010, 2'd0, 2'd1, 2'd2, 8'h00, 5);
        issue(1'b0, 3'b101, 2'd1, 2'd1, 2'd2, 8'h00, 0);
        readback(2'd1);

        // Reset during EXEC of an ADD into r2.
        in_valid = 1'b1; in_ld = 1'b0; in_op = 3'b010; in_rd = 2'd2; in_rs1 = 2'd1; in_rs2 = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_exec", 32'(alu_funsel), 32'd2);
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_funsel", 32'(alu_funsel), 32'd0);
        for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
        end
        for (int r = 0; r < 4; r++) readback(2'(r));

        for (int t = 0; t < 60; t++) begin
            logic ld;
            ld = ($urandom_range(0, 3) == 0);
            issue(ld, 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        for (int r = 0; r < 4; r++) readback(2'(r));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Issue sequencer that sits directly upstream of the 8-bit combinational ALU (`alu8`) and also captures what it produces. It accepts one instruction at a time over a valid/ready handshake and reads two operands from a local 4×8 register file. It drives `funSel`, `a` and `b` into the ALU for exactly one cycle, then writes the result back to the register file. The result and zero flag are presented downstream on a second valid/ready handshake.

## Interface
Parameters:
- none; widths are fixed: 8-bit data, 3-bit function select, 4 registers.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: sequencer can accept an instruction.
- `in_ld` in 1: 1 = load immediate, 0 = ALU operation.
- `in_op` in 3: ALU function select.
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT.
  - 100/101/110 reserved.
- `in_rd` in 2: destination register index.
- `in_rs1` in 2: source register index for operand a.
- `in_rs2` in 2: source register index for operand b.
- `in_imm` in 8: immediate value; used only when `in_ld`=1.
- `alu_funsel` out 3: to ALU `funSel`.
- `alu_a` out 8: to ALU `a`.
- `alu_b` out 8: to ALU `b`.
- `alu_result` in 8: from ALU `result`.
- `alu_zero` in 1: from ALU `zeroFlag`.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 8: captured result.
- `out_zero` out 1: captured zero flag.
- `out_err` out 1: reserved-opcode trap indication; see Configuration.

## Operation
- FSM states: IDLE, EXEC, OUT. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `in_ld`, `in_op`, `in_rd`, `in_rs1`, `in_rs2` and `in_imm`, then go to EXEC.
- EXEC (always exactly one cycle):
  - Drive `alu_funsel`=latched op, `alu_a`=rf[rs1], `alu_b`=rf[rs2]. The register file read is combinational.
  - ALU op, at the end of the cycle: rf[rd]←`alu_result`, `out_data`←`alu_result`, `out_zero`←`alu_zero`.
  - Load immediate: rf[rd]←imm, `out_data`←imm, `out_zero`←(imm==0). The ALU ports are driven 0 in this case.
  - Next state is OUT.
- OUT:
  - `out_valid`=1; `out_data`, `out_zero` and `out_err` are held stable.
  - On `out_ready`, go to IDLE.
- Outside EXEC, `alu_funsel`, `alu_a` and `alu_b` are driven 0.
- Register collisions:
  - rd equal to rs1 or rs2 is legal.
  - Operands are read in EXEC, before the write edge, so the old value is used.
- SUB wraps modulo 256: 3−5 = 0xFE.
- SLT is unsigned, per the ALU.
- Reserved opcodes without the macro pass through to the ALU and produce 0, with zero=1. That 0 is written to rd.
- No instruction is accepted while in EXEC or OUT (`in_ready`=0).

## Timing
- Handshake in cycle N.
  - EXEC in N+1.
  - `out_valid` rises in N+2.
  - Earliest next accept is in N+3 if `out_ready` is held high.
  - Peak throughput is one instruction per 3 cycles.
- `out_valid` stays high through any number of `out_ready`=0 cycles.
- Reset values:
  - state IDLE, so `in_ready`=1.
  - `out_valid`=0, `out_data`=0x00, `out_zero`=0, `out_err`=0.
  - ALU drive ports 0.
  - All four registers 0x00.
- Handshakes while `rst`=1 are ignored.
- Reset asserted mid-operation (EXEC or OUT):
  - Aborts immediately and asynchronously.
  - No register write completes.
  - The pending result is discarded.

## Configuration
- `ALU_ISSUE_SEQ_RESERVED_TRAP_EN` defined:
  - Reserved opcodes 100/101/110 are accepted but not issued: the ALU ports stay 0 in EXEC.
  - rd is not written.
  - OUT presents `out_data`=0x00, `out_zero`=0, `out_err`=1.
  - Latency is unchanged.
- `ALU_ISSUE_SEQ_RESERVED_TRAP_EN` undefined:
  - Reserved opcodes execute normally.
  - `out_err` is tied to 0.

## Test plan
- Reset, then load r1=0x05 and r2=0x03 with `out_ready`=1.
  - Each load gives `out_valid` 2 cycles after its handshake.
  - `out_data` is 0x05, then 0x03; `out_zero`=0.
- ADD r0=r1+r2 → `alu_funsel`=010, a=0x05, b=0x03 in EXEC; `out_data`=0x08; r0 reads back 0x08.
- SUB r3=r2−r1 → `out_data`=0xFE.
- SUB r3=r1−r1 → `out_data`=0x00, `out_zero`=1.
- SLT r0=r2,r1 → 0x01. SLT r0=r1,r2 → 0x00.
- Hold `out_ready`=0 for 5 cycles after an ADD.
  - `out_valid` and `out_data` stay stable; `in_ready` stays 0; a second `in_valid` is not accepted.
  - Release → accept in the following cycle.
- Sequence: issue op 101 targeting r1=0x05.
  - Undefined macro: r1 becomes 0x00, `out_zero`=1.
  - Defined macro: `out_err`=1 and r1 remains 0x05.
- Assert `rst` during EXEC of an ADD into r2 → `out_valid` never rises; all registers 0x00; `in_ready`=1 after release.
